mem_lsu: RTL
============

# mem_lsu

Load/store unit sitting between the MIPS core datapath and `data_mem`, acting as the initiator on the word-wide memory port. It accepts one byte, halfword or word access at a time from the core and translates it into aligned word reads and writes. Sub-word stores use read-modify-write, and load data is lane-extracted and sign- or zero-extended. Misaligned accesses are rejected with an error response and never reach memory.

## Interface
Parameters:
- `ADDR_W`, default 32: width of core and memory addresses.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core request strobe.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_signed`  in  1  sign-extend loads when 1; ignored for stores and word loads.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse. There is no backpressure.
- `resp_err`  out  1  qualifies `resp_valid`: 1 = misaligned or illegal access.
- `resp_rdata`  out  32  load result. It is 0 for stores and errors.
- `mem_addr`  out  ADDR_W  word-aligned address, `{addr[ADDR_W-1:2],2'b00}`.
- `mem_write_en`  out  1  memory write strobe; memory commits on the rising edge.
- `mem_wdata`  out  32  word written to memory.
- `mem_rdata`  in  32  combinational read data for `mem_addr`.

## Operation
- Lane mapping is little-endian.
  - Byte k (`addr[1:0]=k`) occupies bits [8k+7:8k].
  - Half h (`addr[1]=h`) occupies bits [16h+15:16h].
- On accept, `addr`, `write`, `size`, `signed` and `wdata` are registered. The core inputs are not used again until the next accept.
- Misaligned or illegal means any of: `size=11`; half with `addr[0]=1`; word with `addr[1:0]!=0`.
- FSM states and transitions:
  - IDLE → ERR if misaligned; → LOAD if load; → STORE if store word; → RMW_RD if store byte/half.
  - LOAD: drives `mem_addr`. Captures the extracted and extended lane into `resp_rdata`. → RESP.
  - RMW_RD: drives `mem_addr`. Registers `mem_rdata` as the merge base. → STORE.
  - STORE: drives `mem_addr`, `mem_write_en=1`, and `mem_wdata`.
    - For a word store, `mem_wdata` is the registered `wdata`.
    - For a sub-word store, `mem_wdata` is the merge base with the target lane replaced by `wdata[7:0]` or `wdata[15:0]`.
    - → RESP.
  - RESP: `resp_valid=1`, `resp_err=0`. → IDLE.
  - ERR: `resp_valid=1`, `resp_err=1`, `resp_rdata=0`, no memory write. → IDLE.
- Load extension: when `signed=1`, replicate the lane MSB into the upper bits; otherwise fill the upper bits with zeros.
- Outside LOAD, RMW_RD and STORE: `mem_addr=0`, `mem_wdata=0`, `mem_write_en=0`.
- Only one request is outstanding at a time. `req_valid` while not ready is ignored and not queued.

## Timing
- Reset values: state = IDLE, `req_ready=1`, and `resp_valid`, `resp_err`, `resp_rdata`, `mem_addr`, `mem_write_en`, `mem_wdata` all 0.
- Latency from the accept edge to the cycle `resp_valid` is high:
  - error: 1 cycle;
  - load and word store: 2 cycles;
  - byte/half store: 3 cycles.
- `mem_write_en` is high for exactly one cycle per store and zero cycles for loads and errors.
- `resp_rdata` holds its value until the next response. It is cleared when a store or error response is issued.
- Back-to-back requests: with `req_valid` held high, the next accept occurs in the cycle after RESP or ERR, i.e. when the unit returns to IDLE.
- Reset asserted mid-operation: the FSM returns immediately to IDLE and all outputs go to their reset values.
  - No write strobe may be issued after reset release for the aborted request.
  - No `resp_valid` may be issued for the aborted request.

## Test plan
- Word store then loads, memory held in reset-cleared state:
  - store word 0x8899AABB @0x10 → one `mem_write_en` pulse with `mem_addr=0x10`;
  - load word @0x10 → `resp_rdata=0x8899AABB`, 2-cycle latency.
- Sub-word loads, with 0x8899AABB @0x10:
  - signed byte @0x13 → 0xFFFFFF88;
  - unsigned byte @0x13 → 0x00000088;
  - signed half @0x12 → 0xFFFF8899;
  - unsigned half @0x10 → 0x0000AABB.
- Read-modify-write:
  - store byte 0x5A @0x11 → one RMW_RD cycle, then write 0x88995ABB to 0x10; response 3 cycles after accept;
  - store half 0x1234 @0x12 → word becomes 0x12345ABB.
- Errors:
  - load word @0x06, store half @0x03, `size=11` @0x00 → each gives `resp_err=1` one cycle after accept, `mem_write_en` never asserted, `resp_rdata=0`.
- Back-to-back: `req_valid` held for three loads → `req_ready` low during busy cycles, each response exactly 2 cycles after its accept, no request dropped or duplicated.
- Reset in RMW_RD for store byte @0x21 → all outputs 0 during reset, no `mem_write_en` after release, `req_ready=1` on the first cycle after release.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit: turns byte/half/word core accesses into aligned word accesses,
// using read-modify-write for sub-word stores and lane extraction for loads.
module mem_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_STORE  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [31:0]       wdata_q;
    logic [31:0]       base_q, base_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              accept;
    logic              misaligned;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    assign accept     = req_valid && (state_q == S_IDLE);
    assign misaligned = (req_size == 2'b11)
                     || (req_size == 2'b01 && req_addr[0])
                     || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    assign byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign half_lane = mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = {{16{signed_q & half_lane[15]}}, half_lane};
            default: load_ext = mem_rdata;
        endcase
    end

    // Sub-word stores overwrite only the addressed lane of the word read in RMW_RD.
    always_comb begin
        merged = base_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_d = S_ERR;
                        rdata_d = 32'd0;
                    end else if (!req_write) begin
                        state_d = S_LOAD;
                    end else if (req_size == 2'b10) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = load_ext;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                base_d  = mem_rdata;
                state_d = S_STORE;
            end
            S_STORE: begin
                rdata_d = 32'd0;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            wdata_q  <= 32'd0;
            base_q   <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            rdata_q <= rdata_d;
            if (accept) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
            end
        end
    end

    logic mem_active;
    assign mem_active = (state_q == S_LOAD) || (state_q == S_RMW_RD) || (state_q == S_STORE);

    assign req_ready    = (state_q == S_IDLE);
    assign resp_valid   = (state_q == S_RESP) || (state_q == S_ERR);
    assign resp_err     = (state_q == S_ERR);
    assign resp_rdata   = rdata_q;
    assign mem_addr     = mem_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_write_en = (state_q == S_STORE);
    assign mem_wdata    = (state_q == S_STORE) ? merged : 32'd0;
endmodule
